// File: rtl/glyph_decoder.sv
// Decodes 4-column active-low LED glyphs into BCD digits; result valid 2 edges after the 4th column.
// col_ready only in COLLECT; result held in OUTPUT until dig_ready handshake, stalling further columns.
module glyph_decoder #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       col_data,
    input  logic             col_valid,
    input  logic             col_sof,
    output logic             col_ready,
    output logic [3:0]       dig_bcd,
    output logic             dig_err,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        MATCH   = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][7:0]  buf_q, buf_d;
    logic [3:0]       bcd_q, bcd_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [31:0]      glyph;
    logic             hit;
    logic [3:0]       hit_bcd;

    // Column 0 sits in the most significant byte so the table reads as written.
    assign glyph = {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};

    always_comb begin
        hit     = 1'b1;
        hit_bcd = 4'd0;
        case (glyph)
            32'h007E_7E00: hit_bcd = 4'd0;
            32'hFFFF_00FF: hit_bcd = 4'd1;
            32'h6061_6E0E: hit_bcd = 4'd2;
            32'h6E6E_6E00: hit_bcd = 4'd3;
            32'h0FE0_EF00: hit_bcd = 4'd4;
            32'h0E6E_6E60: hit_bcd = 4'd5;
            32'h006E_6E60: hit_bcd = 4'd6;
            32'h7F7F_7F00: hit_bcd = 4'd7;
            32'h006E_6E00: hit_bcd = 4'd8;
            32'h0E6E_6E00: hit_bcd = 4'd9;
            default: begin
                hit     = 1'b0;
                hit_bcd = 4'hF;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            COLLECT: begin
                if (col_valid) begin
                    if (col_sof) begin
                        buf_d[0] = col_data;
                        idx_d    = 2'd1;
                    end else if (idx_q != 2'd0) begin
                        // Non-sof columns with no glyph in progress fall through and are dropped.
                        buf_d[idx_q] = col_data;
                        idx_d        = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = MATCH;
                        end
                    end
                end
            end
            MATCH: begin
                bcd_d   = hit_bcd;
                err_d   = ~hit;
                if (!hit && (cnt_q != {ERR_W{1'b1}})) begin
                    cnt_d = cnt_q + ERR_W'(1);
                end
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (dig_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= 2'd0;
            buf_q   <= '0;
            bcd_q   <= 4'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign col_ready = (state_q == COLLECT);
    assign dig_valid = (state_q == OUTPUT);
    assign dig_bcd   = bcd_q;
    assign dig_err   = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_glyph_decoder.sv
// Bench for glyph_decoder: table-driven glyph vectors with a result scoreboard, plus hand sequences.
module tb_glyph_decoder;

    localparam int ERR_W = 8;

    logic             clk;
    logic             rst_n;
    logic [7:0]       col_data;
    logic             col_valid;
    logic             col_sof;
    logic             col_ready;
    logic [3:0]       dig_bcd;
    logic             dig_err;
    logic             dig_valid;
    logic             dig_ready;
    logic [ERR_W-1:0] err_cnt;

    glyph_decoder #(.ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_data  (col_data),
        .col_valid (col_valid),
        .col_sof   (col_sof),
        .col_ready (col_ready),
        .dig_bcd   (dig_bcd),
        .dig_err   (dig_err),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] glyph;
        logic [3:0]  bcd;
        logic        err;
    } vec_t;

    typedef struct {
        logic [3:0]       bcd;
        logic             err;
        logic [ERR_W-1:0] cnt;
    } exp_t;

    exp_t             sb_q[$];
    logic [ERR_W-1:0] exp_cnt;
    int               n_checks;
    int               n_pass;
    vec_t             vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic push_exp(input logic [3:0] bcd, input logic err);
        exp_t e;
        if (err && exp_cnt != {ERR_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        e.bcd = bcd;
        e.err = err;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    // Returns one time unit after the edge that accepted the column.
    task automatic send_col(input logic [7:0] d, input logic sof);
        bit ok;
        ok        = 0;
        col_data  = d;
        col_sof   = sof;
        col_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (col_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail("col_accept");
        else begin
            @(posedge clk);
            #1;
        end
        col_valid = 1'b0;
        col_sof   = 1'b0;
    endtask

    task automatic send_glyph(input logic [31:0] g);
        logic [31:0] t;
        t = g;
        send_col(t[31:24], 1'b1);
        send_col(t[23:16], 1'b0);
        send_col(t[15:8],  1'b0);
        send_col(t[7:0],   1'b0);
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dig_valid(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dig_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col_ready"}, 32'(col_ready), 32'd1);
        check({tag, "_dig_valid"}, 32'(dig_valid), 32'd0);
        check({tag, "_dig_bcd"},   32'(dig_bcd),   32'd0);
        check({tag, "_dig_err"},   32'(dig_err),   32'd0);
        check({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
    endtask

    // Result monitor: a handshake sampled here completes on the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && dig_valid && dig_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got bcd 0x%0h with nothing expected at %0t", dig_bcd, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_bcd", 32'(dig_bcd), 32'(e.bcd));
                    check("sb_err", 32'(dig_err), 32'(e.err));
                    check("sb_cnt", 32'(err_cnt), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h007E_7E00, 4'd0, 1'b0};
        vecs[1]  = '{32'hFFFF_00FF, 4'd1, 1'b0};
        vecs[2]  = '{32'h6061_6E0E, 4'd2, 1'b0};
        vecs[3]  = '{32'h6E6E_6E00, 4'd3, 1'b0};
        vecs[4]  = '{32'h0FE0_EF00, 4'd4, 1'b0};
        vecs[5]  = '{32'h0E6E_6E60, 4'd5, 1'b0};
        vecs[6]  = '{32'h006E_6E60, 4'd6, 1'b0};
        vecs[7]  = '{32'h7F7F_7F00, 4'd7, 1'b0};
        vecs[8]  = '{32'h006E_6E00, 4'd8, 1'b0};
        vecs[9]  = '{32'h0E6E_6E00, 4'd9, 1'b0};
        vecs[10] = '{32'h007E_FF00, 4'hF, 1'b1};

        n_checks  = 0;
        n_pass    = 0;
        exp_cnt   = '0;
        rst_n     = 1'b0;
        col_data  = 8'h00;
        col_valid = 1'b0;
        col_sof   = 1'b0;
        dig_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // Glyph 3 with exact latency from the 4th column edge.
        @(posedge clk);
        #1;
        push_exp(4'd3, 1'b0);
        send_glyph(32'h6E6E_6E00);
        @(negedge clk);
        check("lat_match_valid", 32'(dig_valid), 32'd0);
        check("lat_match_ready", 32'(col_ready), 32'd0);
        @(negedge clk);
        check("lat_out_valid", 32'(dig_valid), 32'd1);
        check("lat_out_bcd",   32'(dig_bcd),   32'd3);
        wait_drain("drain_glyph3");

        // All table glyphs back-to-back, then the single mismatch entry.
        for (int i = 0; i < 11; i++) begin
            push_exp(vecs[i].bcd, vecs[i].err);
            send_glyph(vecs[i].glyph);
        end
        wait_drain("drain_table");
        check("cnt_after_one_bad", 32'(err_cnt), 32'd1);

        // Restart mid-glyph, then a stray non-sof column while idle.
        push_exp(4'd4, 1'b0);
        send_col(8'hFF, 1'b1);
        send_col(8'hFF, 1'b0);
        send_glyph(32'h0FE0_EF00);
        wait_drain("drain_restart");
        push_exp(4'd8, 1'b0);
        send_col(8'h6E, 1'b0);
        send_glyph(32'h006E_6E00);
        wait_drain("drain_idle_col");

        // Backpressure: result held, columns refused, next glyph after handshake.
        dig_ready = 1'b0;
        push_exp(4'd7, 1'b0);
        send_glyph(32'h7F7F_7F00);
        wait_dig_valid("bp_valid");
        push_exp(4'd5, 1'b0);
        col_data  = 8'h0E;
        col_sof   = 1'b1;
        col_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(dig_valid), 32'd1);
            check("bp_hold_bcd",   32'(dig_bcd),   32'd7);
            check("bp_col_ready",  32'(col_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        dig_ready = 1'b1;
        send_col(8'h0E, 1'b1);
        send_col(8'h6E, 1'b0);
        send_col(8'h6E, 1'b0);
        send_col(8'h60, 1'b0);
        wait_drain("drain_bp");

        // Counter saturation.
        for (int i = 0; i < (1 << ERR_W) + 3; i++) begin
            push_exp(4'hF, 1'b1);
            send_glyph(32'h007E_FF00);
        end
        wait_drain("drain_sat");
        check("cnt_saturated", 32'(err_cnt), 32'hFF);

        // Reset after two columns.
        send_col(8'h60, 1'b1);
        send_col(8'h61, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("rst_mid_glyph");
        exp_cnt = '0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst1_release_ready", 32'(col_ready), 32'd1);
        @(posedge clk);
        #1;
        push_exp(4'd2, 1'b0);
        send_glyph(32'h6061_6E0E);
        wait_drain("drain_rst1");

        // Reset while a mismatch result is waiting in OUTPUT.
        dig_ready = 1'b0;
        send_glyph(32'h007E_FF00);
        wait_dig_valid("rst2_valid");
        check("rst2_pre_cnt", 32'(err_cnt), 32'd1);
        check("rst2_pre_bcd", 32'(dig_bcd), 32'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("rst_in_output");
        exp_cnt = '0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        dig_ready = 1'b1;
        @(negedge clk);
        check("rst2_release_ready", 32'(col_ready), 32'd1);
        @(posedge clk);
        #1;
        push_exp(4'd9, 1'b0);
        send_glyph(32'h0E6E_6E00);
        wait_drain("drain_rst2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
